// File: rtl/ase_pcie_tx_ab_arb.sv
// ----------------------------------------------------------------------------
// ase_pcie_tx_ab_arb
//
// Packet-atomic arbiter that merges the AFU's two PCIe SS TX AXI-S streams
// (TX-A and TX-B) into one TX stream for the ASE PCIe SS emulation core.
// Each input is buffered in a small FIFO. Whole packets are granted
// round-robin, and a granted packet is never interleaved with the other
// input. Per-input completed-packet counters are kept for debug.
//
// Ports:
//   clk, rst_n              clock (pClk domain), async active-low reset
//   a_t* / b_t*             TX-A / TX-B AXI-S slave inputs (tready is output)
//   o_t*                    merged AXI-S master output (o_tready is input)
//   o_src                   source of the current output beat (0=A, 1=B)
//   pkt_cnt_a, pkt_cnt_b    packets from A / B completed at the output
// ----------------------------------------------------------------------------
module ase_pcie_tx_ab_arb #(
    parameter int TDATA_WIDTH = 512,
    parameter int TUSER_WIDTH = 10,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     a_tvalid,
    output logic                     a_tready,
    input  logic [TDATA_WIDTH-1:0]   a_tdata,
    input  logic [TDATA_WIDTH/8-1:0] a_tkeep,
    input  logic                     a_tlast,
    input  logic [TUSER_WIDTH-1:0]   a_tuser,

    input  logic                     b_tvalid,
    output logic                     b_tready,
    input  logic [TDATA_WIDTH-1:0]   b_tdata,
    input  logic [TDATA_WIDTH/8-1:0] b_tkeep,
    input  logic                     b_tlast,
    input  logic [TUSER_WIDTH-1:0]   b_tuser,

    output logic                     o_tvalid,
    input  logic                     o_tready,
    output logic [TDATA_WIDTH-1:0]   o_tdata,
    output logic [TDATA_WIDTH/8-1:0] o_tkeep,
    output logic                     o_tlast,
    output logic [TUSER_WIDTH-1:0]   o_tuser,
    output logic                     o_src,

    output logic [CNT_WIDTH-1:0]     pkt_cnt_a,
    output logic [CNT_WIDTH-1:0]     pkt_cnt_b
);

    localparam int KEEP_WIDTH = TDATA_WIDTH / 8;
    localparam int BEAT_WIDTH = TDATA_WIDTH + KEEP_WIDTH + 1 + TUSER_WIDTH;
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    // Beat packing is {tdata, tkeep, tlast, tuser}; tlast sits at TUSER_WIDTH.
    localparam int LAST_BIT = TUSER_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFOs, index 0 = TX-A, index 1 = TX-B
    // ------------------------------------------------------------------
    logic [1:0]            inValid;
    logic [1:0]            push;
    logic [1:0]            pop;
    logic [1:0]            empty;
    logic [1:0]            readyQ;
    logic [1:0]            rdLast;
    logic [BEAT_WIDTH-1:0] inBeat  [2];
    logic [BEAT_WIDTH-1:0] rdBeat  [2];
    logic [BEAT_WIDTH-1:0] fifoMem [2][FIFO_DEPTH];
    logic [AW-1:0]         wrPtr   [2];
    logic [AW-1:0]         rdPtr   [2];
    logic [AW:0]           count   [2];
    logic [AW:0]           countNext [2];

    assign inValid   = {b_tvalid, a_tvalid};
    assign inBeat[0] = {a_tdata, a_tkeep, a_tlast, a_tuser};
    assign inBeat[1] = {b_tdata, b_tkeep, b_tlast, b_tuser};

    // Ready is a flop so it is low throughout reset and tracks "not full"
    // one edge after each occupancy change.
    assign a_tready = readyQ[0];
    assign b_tready = readyQ[1];

    always_comb begin
        push   = '0;
        empty  = '0;
        rdLast = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            push[i]   = inValid[i] & readyQ[i];
            empty[i]  = (count[i] == '0);
            rdBeat[i] = fifoMem[i][rdPtr[i]];
            rdLast[i] = rdBeat[i][LAST_BIT];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            countNext[i] = count[i];
            if (push[i] && !pop[i]) begin
                countNext[i] = count[i] + 1'b1;
            end else if (pop[i] && !push[i]) begin
                countNext[i] = count[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 2; i++) begin
            if (push[i]) begin
                fifoMem[i][wrPtr[i]] <= inBeat[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readyQ <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                wrPtr[i] <= '0;
                rdPtr[i] <= '0;
                count[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (push[i]) begin
                    wrPtr[i] <= wrPtr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rdPtr[i] <= rdPtr[i] + 1'b1;
                end
                count[i]  <= countNext[i];
                readyQ[i] <= (countNext[i] != FULL_CNT);
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbiter FSM
    // ------------------------------------------------------------------
    state_t                state;
    state_t                stateNext;
    logic                  lastGrantB;
    logic                  lastGrantBNext;
    logic                  loadEn;
    logic                  oValid;
    logic                  oSrc;
    logic [BEAT_WIDTH-1:0] oBeat;

    assign loadEn = ~oValid | o_tready;

    always_comb begin
        pop            = '0;
        stateNext      = state;
        lastGrantBNext = lastGrantB;

        if (loadEn) begin
            unique case (state)
                IDLE: begin
                    // A wins when B is empty or B held the last grant.
                    if (!empty[0] && (empty[1] || lastGrantB)) begin
                        pop[0] = 1'b1;
                    end else if (!empty[1]) begin
                        pop[1] = 1'b1;
                    end
                end
                GNT_A:   pop[0] = ~empty[0];
                GNT_B:   pop[1] = ~empty[1];
                default: pop    = '0;
            endcase
        end

        // Common exit handling: tlast closes the packet from either IDLE
        // or GNT_x; a non-last beat holds (or takes) the grant.
        if (pop[0]) begin
            if (rdLast[0]) begin
                stateNext      = IDLE;
                lastGrantBNext = 1'b0;
            end else begin
                stateNext = GNT_A;
            end
        end else if (pop[1]) begin
            if (rdLast[1]) begin
                stateNext      = IDLE;
                lastGrantBNext = 1'b1;
            end else begin
                stateNext = GNT_B;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lastGrantB <= 1'b1;
        end else begin
            state      <= stateNext;
            lastGrantB <= lastGrantBNext;
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oValid <= 1'b0;
            oSrc   <= 1'b0;
            oBeat  <= '0;
        end else if (loadEn) begin
            oValid <= pop[0] | pop[1];
            if (pop[0]) begin
                oBeat <= rdBeat[0];
                oSrc  <= 1'b0;
            end else if (pop[1]) begin
                oBeat <= rdBeat[1];
                oSrc  <= 1'b1;
            end
        end
    end

    assign o_tvalid = oValid;
    assign o_src    = oSrc;
    assign {o_tdata, o_tkeep, o_tlast, o_tuser} = oBeat;

    // ------------------------------------------------------------------
    // Completed-packet counters (wrap naturally)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_a <= '0;
            pkt_cnt_b <= '0;
        end else if (oValid && o_tready && o_tlast) begin
            if (oSrc) begin
                pkt_cnt_b <= pkt_cnt_b + 1'b1;
            end else begin
                pkt_cnt_a <= pkt_cnt_a + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ase_pcie_tx_ab_arb.sv
// ----------------------------------------------------------------------------
// tb_ase_pcie_tx_ab_arb
//
// Self-checking bench for ase_pcie_tx_ab_arb. A queue-based model tracks the
// beats accepted on each input and decides, packet by packet, which beat the
// output register must hold. Directed scenarios add literal expectations.
// ----------------------------------------------------------------------------
module tb_ase_pcie_tx_ab_arb;

    localparam int DW    = 64;
    localparam int UW    = 10;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 4;
    localparam int CW    = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    typedef struct {
        beat_t b;
        int    gap;
    } stim_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_tvalid = 1'b0, b_tvalid = 1'b0;
    logic          a_tready, b_tready;
    logic [DW-1:0] a_tdata = '0, b_tdata = '0;
    logic [KW-1:0] a_tkeep = '0, b_tkeep = '0;
    logic          a_tlast = 1'b0, b_tlast = 1'b0;
    logic [UW-1:0] a_tuser = '0, b_tuser = '0;
    logic          o_tvalid, o_tready = 1'b1;
    logic [DW-1:0] o_tdata;
    logic [KW-1:0] o_tkeep;
    logic          o_tlast;
    logic [UW-1:0] o_tuser;
    logic          o_src;
    logic [CW-1:0] pkt_cnt_a, pkt_cnt_b;

    ase_pcie_tx_ab_arb #(
        .TDATA_WIDTH(DW),
        .TUSER_WIDTH(UW),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_tvalid (a_tvalid),
        .a_tready (a_tready),
        .a_tdata  (a_tdata),
        .a_tkeep  (a_tkeep),
        .a_tlast  (a_tlast),
        .a_tuser  (a_tuser),
        .b_tvalid (b_tvalid),
        .b_tready (b_tready),
        .b_tdata  (b_tdata),
        .b_tkeep  (b_tkeep),
        .b_tlast  (b_tlast),
        .b_tuser  (b_tuser),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready),
        .o_tdata  (o_tdata),
        .o_tkeep  (o_tkeep),
        .o_tlast  (o_tlast),
        .o_tuser  (o_tuser),
        .o_src    (o_src),
        .pkt_cnt_a(pkt_cnt_a),
        .pkt_cnt_b(pkt_cnt_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic beat_t mkBeat(input logic [7:0] tag, input logic last);
        beat_t b;
        b.data = {8{tag}};
        b.keep = tag ^ 8'hA5;
        b.last = last;
        b.user = {2'b01, tag};
        return b;
    endfunction

    // ---------------- stimulus queues and drivers ----------------
    stim_t stimA[$];
    stim_t stimB[$];

    task automatic pushA(input logic [7:0] tag, input logic last, input int gap);
        stim_t s;
        s.b   = mkBeat(tag, last);
        s.gap = gap;
        stimA.push_back(s);
    endtask

    task automatic pushB(input logic [7:0] tag, input logic last, input int gap);
        stim_t s;
        s.b   = mkBeat(tag, last);
        s.gap = gap;
        stimB.push_back(s);
    endtask

    initial begin : drvA
        bit loaded = 1'b0;
        int gapLeft = 0;
        forever begin
            @(posedge clk);
            if (a_tvalid && a_tready) begin
                void'(stimA.pop_front());
                loaded = 1'b0;
            end
            #1;
            if (stimA.size() == 0) begin
                a_tvalid = 1'b0;
                loaded   = 1'b0;
            end else begin
                if (!loaded) begin
                    gapLeft = stimA[0].gap;
                    loaded  = 1'b1;
                end
                if (gapLeft > 0) begin
                    gapLeft--;
                    a_tvalid = 1'b0;
                end else begin
                    a_tvalid = 1'b1;
                    {a_tdata, a_tkeep, a_tlast, a_tuser} = stimA[0].b;
                end
            end
        end
    end

    initial begin : drvB
        bit loaded = 1'b0;
        int gapLeft = 0;
        forever begin
            @(posedge clk);
            if (b_tvalid && b_tready) begin
                void'(stimB.pop_front());
                loaded = 1'b0;
            end
            #1;
            if (stimB.size() == 0) begin
                b_tvalid = 1'b0;
                loaded   = 1'b0;
            end else begin
                if (!loaded) begin
                    gapLeft = stimB[0].gap;
                    loaded  = 1'b1;
                end
                if (gapLeft > 0) begin
                    gapLeft--;
                    b_tvalid = 1'b0;
                end else begin
                    b_tvalid = 1'b1;
                    {b_tdata, b_tkeep, b_tlast, b_tuser} = stimB[0].b;
                end
            end
        end
    end

    // ---------------- behavioural model ----------------
    beat_t         mqA[$];
    beat_t         mqB[$];
    beat_t         expBeat = '0;
    logic          expValid = 1'b0, expSrc = 1'b0;
    logic          expRdyA = 1'b0, expRdyB = 1'b0;
    logic          lastWasB = 1'b1;
    int            owner = 0;            // 0 none, 1 A mid-packet, 2 B mid-packet
    logic [CW-1:0] expCntA = '0, expCntB = '0;

    logic [7:0]    outTag[$];
    logic          outSrc[$];
    int            outCyc[$];
    logic [7:0]    wantTags[$];
    bit            stallWin = 1'b0;
    int            stallAcc = 0;

    initial begin : model
        bit    got;
        bit    takeB;
        beat_t nb;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mqA.delete();
                mqB.delete();
                expValid = 1'b0;
                expSrc   = 1'b0;
                expBeat  = '0;
                expRdyA  = 1'b0;
                expRdyB  = 1'b0;
                lastWasB = 1'b1;
                owner    = 0;
                expCntA  = '0;
                expCntB  = '0;
            end else begin
                cyc++;
                if (o_tvalid && o_tready) begin
                    outTag.push_back(o_tdata[7:0]);
                    outSrc.push_back(o_src);
                    outCyc.push_back(cyc);
                end
                if (stallWin && a_tvalid && a_tready) stallAcc++;

                if (expValid && o_tready && expBeat.last) begin
                    if (expSrc) expCntB = expCntB + 1'b1;
                    else        expCntA = expCntA + 1'b1;
                end

                if (!expValid || o_tready) begin
                    got   = 1'b0;
                    takeB = 1'b0;
                    if (owner == 1) begin
                        got = (mqA.size() != 0);
                    end else if (owner == 2) begin
                        got   = (mqB.size() != 0);
                        takeB = 1'b1;
                    end else if (mqA.size() != 0 && (mqB.size() == 0 || lastWasB)) begin
                        got = 1'b1;
                    end else if (mqB.size() != 0) begin
                        got   = 1'b1;
                        takeB = 1'b1;
                    end
                    expValid = got;
                    if (got) begin
                        expBeat = takeB ? mqB.pop_front() : mqA.pop_front();
                        expSrc  = takeB;
                        if (expBeat.last) begin
                            owner    = 0;
                            lastWasB = takeB;
                        end else begin
                            owner = takeB ? 2 : 1;
                        end
                    end
                end

                if (a_tvalid && expRdyA) begin
                    nb = {a_tdata, a_tkeep, a_tlast, a_tuser};
                    mqA.push_back(nb);
                end
                if (b_tvalid && expRdyB) begin
                    nb = {b_tdata, b_tkeep, b_tlast, b_tuser};
                    mqB.push_back(nb);
                end
                expRdyA = (mqA.size() != DEPTH);
                expRdyB = (mqB.size() != DEPTH);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("o_tvalid", 64'(o_tvalid), 64'(expValid));
                if (expValid) begin
                    check("o_tdata", o_tdata, expBeat.data);
                    check("o_tkeep", 64'(o_tkeep), 64'(expBeat.keep));
                    check("o_tlast", 64'(o_tlast), 64'(expBeat.last));
                    check("o_tuser", 64'(o_tuser), 64'(expBeat.user));
                    check("o_src", 64'(o_src), 64'(expSrc));
                end
                check("a_tready", 64'(a_tready), 64'(expRdyA));
                check("b_tready", 64'(b_tready), 64'(expRdyB));
                check("pkt_cnt_a", 64'(pkt_cnt_a), 64'(expCntA));
                check("pkt_cnt_b", 64'(pkt_cnt_b), 64'(expCntB));
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic waitIdle(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (stimA.size() == 0 && stimB.size() == 0 && mqA.size() == 0 &&
                mqB.size() == 0 && !expValid && !a_tvalid && !b_tvalid) begin
                done = 1'b1;
                break;
            end
        end
        check(name, 64'(done), 64'd1);
    endtask

    task automatic clearLog();
        outTag.delete();
        outSrc.delete();
        outCyc.delete();
        wantTags.delete();
    endtask

    task automatic checkLog(input string name);
        check({name, "_len"}, 64'(outTag.size()), 64'(wantTags.size()));
        for (int i = 0; i < wantTags.size() && i < outTag.size(); i++) begin
            check(name, 64'(outTag[i]), 64'(wantTags[i]));
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        stimA.delete();
        stimB.delete();
        a_tvalid = 1'b0;
        b_tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin : main
        bit seen;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_a_tready", 64'(a_tready), 64'd0);
        check("rst_b_tready", 64'(b_tready), 64'd0);
        check("rst_o_tvalid", 64'(o_tvalid), 64'd0);
        check("rst_o_src", 64'(o_src), 64'd0);
        check("rst_o_tlast", 64'(o_tlast), 64'd0);
        check("rst_cnt_a", 64'(pkt_cnt_a), 64'd0);
        check("rst_cnt_b", 64'(pkt_cnt_b), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_a_tready", 64'(a_tready), 64'd1);

        // Single 1-beat packet on A: visible one edge after acceptance
        pushA(8'h11, 1'b1, 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (a_tvalid && a_tready) begin
                seen = 1'b1;
                break;
            end
        end
        check("t1_accept", 64'(seen), 64'd1);
        @(negedge clk);
        check("t1_not_yet", 64'(o_tvalid), 64'd0);
        @(negedge clk);
        check("t1_valid", 64'(o_tvalid), 64'd1);
        check("t1_data", 64'(o_tdata[7:0]), 64'h11);
        check("t1_src", 64'(o_src), 64'd0);
        @(negedge clk);
        check("t1_cnt_a", 64'(pkt_cnt_a), 64'd1);
        check("t1_cnt_b", 64'(pkt_cnt_b), 64'd0);
        waitIdle("t1_idle", 50);

        // Simultaneous 3-beat packets: A first, no interleave, no gap
        doReset();
        clearLog();
        for (int k = 0; k < 3; k++) begin
            pushA(8'hA0 + 8'(k), k == 2, 0);
            pushB(8'hB0 + 8'(k), k == 2, 0);
        end
        waitIdle("t2_idle", 50);
        wantTags = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2};
        checkLog("t2_order");
        for (int i = 1; i < outCyc.size(); i++) begin
            check("t2_nogap", 64'(outCyc[i] - outCyc[i-1]), 64'd1);
        end
        check("t2_cnt_a", 64'(pkt_cnt_a), 64'd1);
        check("t2_cnt_b", 64'(pkt_cnt_b), 64'd1);

        // Continuous 1-beat packets on both inputs: strict alternation,
        // 20 packets each wraps the 4-bit counters to 4
        doReset();
        clearLog();
        for (int k = 0; k < 20; k++) begin
            pushA(8'(k), 1'b1, 0);
            pushB(8'h80 + 8'(k), 1'b1, 0);
        end
        waitIdle("t3_idle", 300);
        check("t3_len", 64'(outSrc.size()), 64'd40);
        for (int i = 0; i < outSrc.size(); i++) begin
            check("t3_alt", 64'(outSrc[i]), 64'(i % 2));
        end
        check("t3_cnt_a", 64'(pkt_cnt_a), 64'd4);
        check("t3_cnt_b", 64'(pkt_cnt_b), 64'd4);

        // Output stalled 10 cycles while A streams an 8-beat packet
        clearLog();
        @(posedge clk);
        #1;
        o_tready = 1'b0;
        stallAcc = 0;
        stallWin = 1'b1;
        for (int k = 0; k < 8; k++) pushA(8'h40 + 8'(k), k == 7, 0);
        repeat (10) @(posedge clk);
        #1;
        stallWin = 1'b0;
        check("t4_accepted", 64'(stallAcc), 64'(DEPTH + 1));
        check("t4_a_tready_low", 64'(a_tready), 64'd0);
        check("t4_held_valid", 64'(o_tvalid), 64'd1);
        check("t4_held_data", 64'(o_tdata[7:0]), 64'h40);
        o_tready = 1'b1;
        waitIdle("t4_idle", 100);
        for (int k = 0; k < 8; k++) wantTags.push_back(8'h40 + 8'(k));
        checkLog("t4_order");

        // A stalls mid-packet while B has a whole packet queued
        clearLog();
        pushA(8'h50, 1'b0, 0);
        pushA(8'h51, 1'b0, 0);
        pushA(8'h52, 1'b0, 5);
        pushA(8'h53, 1'b1, 0);
        pushB(8'h60, 1'b0, 2);
        pushB(8'h61, 1'b0, 0);
        pushB(8'h62, 1'b1, 0);
        waitIdle("t5_idle", 100);
        wantTags = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'h61, 8'h62};
        checkLog("t5_order");

        // Async reset in the middle of an A packet
        clearLog();
        for (int k = 0; k < 4; k++) pushA(8'h70 + 8'(k), k == 3, 0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (outTag.size() >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        check("t6_midpkt", 64'(seen), 64'd1);
        #2;
        rst_n = 1'b0;
        stimA.delete();
        stimB.delete();
        a_tvalid = 1'b0;
        b_tvalid = 1'b0;
        #1;
        check("t6_rst_valid", 64'(o_tvalid), 64'd0);
        check("t6_rst_cnt_a", 64'(pkt_cnt_a), 64'd0);
        check("t6_rst_cnt_b", 64'(pkt_cnt_b), 64'd0);
        check("t6_rst_a_tready", 64'(a_tready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clearLog();
        pushB(8'h90, 1'b0, 0);
        pushB(8'h91, 1'b1, 0);
        waitIdle("t6_idle", 50);
        wantTags = '{8'h90, 8'h91};
        checkLog("t6_order");
        check("t6_cnt_a", 64'(pkt_cnt_a), 64'd0);
        check("t6_cnt_b", 64'(pkt_cnt_b), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ase_pcie_tx_ab_arb.md
Name: ase_pcie_tx_ab_arb

Overview:
- Packet-atomic arbiter that merges the AFU's two PCIe SS TX AXI-S streams (TX-A and TX-B) into one TX stream for the ASE PCIe SS emulation core.
- Sits directly downstream of the afu_main TX-A/TX-B link ports, inside the ASE emulation wrapper.
- Each input is buffered in a small FIFO. Packets are granted round-robin; once granted, a packet is never interleaved with the other input.
- Keeps per-input completed-packet counters for debug.

Parameters:
TDATA_WIDTH, 512, AXI-S data width (pcie_ss_axis_pkg::TDATA_WIDTH)
TUSER_WIDTH, 10, AXI-S user width (pcie_ss_axis_pkg::TUSER_WIDTH)
FIFO_DEPTH, 4, beats per input FIFO; power of 2, >=2
CNT_WIDTH, 16, width of packet counters

Ports:
clk  in  1  clock (pClk domain)
rst_n  in  1  reset, asynchronous, active-low
a_tvalid  in  1  TX-A beat valid
a_tready  out  1  TX-A ready
a_tdata  in  TDATA_WIDTH  TX-A data
a_tkeep  in  TDATA_WIDTH/8  TX-A byte enables
a_tlast  in  1  TX-A end of packet
a_tuser  in  TUSER_WIDTH  TX-A user
b_tvalid, b_tready, b_tdata, b_tkeep, b_tlast, b_tuser  same as the a_* group, for TX-B
o_tvalid  out  1  merged beat valid
o_tready  in  1  merged ready from ASE core
o_tdata  out  TDATA_WIDTH  merged data
o_tkeep  out  TDATA_WIDTH/8  merged byte enables
o_tlast  out  1  merged end of packet
o_tuser  out  TUSER_WIDTH  merged user
o_src  out  1  source of current output beat (0=A, 1=B)
pkt_cnt_a  out  CNT_WIDTH  packets from A completed at output
pkt_cnt_b  out  CNT_WIDTH  packets from B completed at output

Behaviour:
Reset (async assert, synchronous deassert):
- All FIFOs empty; a_tready = b_tready = 0 while rst_n low, and 1 from the first clk edge after release.
- o_tvalid=0, o_src=0, o_tlast=0, pkt_cnt_a=pkt_cnt_b=0, state=IDLE, last_grant=B (so A wins the first tie).
- Reset mid-packet discards all buffered and partial beats; no recovery of partial packets.

Input FIFOs:
- x_tready = ~full_x, registered from occupancy.
- A write occurs on x_tvalid & x_tready; {tdata, tkeep, tlast, tuser} are stored.
- Simultaneous push and pop on a full FIFO is not allowed: tready is already low when full.
- Push and pop in the same cycle on a non-full FIFO keeps occupancy constant.

Output register:
- Single stage; load_en = ~o_tvalid | o_tready.
- Holds data/tkeep/tlast/tuser/o_src stable while o_tvalid & ~o_tready. AXI-S rule: o_tvalid never drops without a handshake.

Arbiter FSM (registered state: IDLE, GNT_A, GNT_B):
- IDLE, load_en, one FIFO non-empty: pop that FIFO into the output register this cycle.
- IDLE, load_en, both non-empty: pop the FIFO != last_grant.
- IDLE, popped beat has tlast=1: stay IDLE and set last_grant to the popped source.
- IDLE, popped beat has tlast=0: go to GNT_x.
- GNT_x: pop only from FIFO x when load_en & ~empty_x. The other FIFO is never popped, even if x is empty (a bubble is allowed).
- GNT_x, popped beat has tlast=1: go to IDLE and set last_grant=x.
- No packet length limit.

Latency:
- A beat written into an empty FIFO at edge N, with the output register free and the arbiter IDLE or granted to that input, appears on o_tvalid after edge N+1.
- Sustained throughput is 1 beat/clk per granted packet.
- Switching sources costs no bubble: a tlast pop in IDLE or GNT lets the next packet pop on the following cycle.

Counters:
- pkt_cnt_src increments by 1 on o_tvalid & o_tready & o_tlast, selected by o_src.
- Counters wrap modulo 2^CNT_WIDTH.

Test Plan:
- Single 1-beat packet on A (tdata=0x11, tlast=1), o_tready=1 -> o_tvalid high after 2nd edge, o_tdata=0x11, o_src=0, pkt_cnt_a=1, pkt_cnt_b=0.
- A and B each present a 3-beat packet in the same cycle, o_tready=1 -> output is A0,A1,A2,B0,B1,B2 with no interleave or gap; pkt_cnt_a=pkt_cnt_b=1.
- Continuous 1-beat packets on both inputs for 20 cycles -> output alternates A,B,A,B...; counts equal ±1.
- o_tready held low 10 cycles with A streaming -> a_tready drops after FIFO_DEPTH+1 accepted beats; o_* stays stable; after release, all beats are delivered in order with no loss or duplication.
- A packet stalls mid-packet (A sends 2 of 4 beats, pauses 5 cycles) while B has a full packet queued -> no B beat appears until A's tlast is output.
- rst_n asserted mid-packet -> o_tvalid=0 and counters=0 immediately (async). After release, a fresh B packet is delivered cleanly and no stale A beats appear.
